// File: rtl/fetch_redirect_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_controller_pkg
// Description : Shared types for the fetch redirect controller: the machine
//               word, the boot address and the redirect-kind encoding.
// Revision    : 1.0  initial release
// ============================================================================
package fetch_redirect_controller_pkg;

  typedef logic [31:0] word;

  localparam word BOOT_ADDRESS = 32'h0000_0000;

  // Encoded so that a numerically larger kind always wins arbitration.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    JAL  = 2'd1,
    EXEC = 2'd2,
    TRAP = 2'd3
  } redirect_kind_t;

  // Highest-priority kind among the raw request lines.
  function automatic redirect_kind_t highest_kind(input logic trap,
                                                  input logic exec,
                                                  input logic jal);
    if (trap)      return TRAP;
    else if (exec) return EXEC;
    else if (jal)  return JAL;
    else           return NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_redirect_controller_slot.sv
`default_nettype none
// ============================================================================
// Module      : redirect_slot
// Description : One-entry holding register for a redirect. A load is taken
//               only when it outranks what the slot already holds; clear
//               empties the slot first so a same-cycle load always lands.
// Revision    : 1.0  initial release
// ============================================================================
module redirect_slot
  import fetch_redirect_controller_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  input  logic           clear,
  input  redirect_kind_t load_kind,
  input  word            load_value,
  output redirect_kind_t kind,
  output word            value,
  output logic           valid
);

  redirect_kind_t base_kind;

  // Contents the incoming load competes against after an optional clear.
  always_comb begin
    base_kind = clear ? NONE : kind;
  end

  // Priority-overwrite storage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kind  <= NONE;
      value <= BOOT_ADDRESS;
    end else if (load_kind > base_kind) begin
      kind  <= load_kind;
      value <= load_value;
    end else begin
      kind  <= base_kind;
    end
  end

  assign valid = (kind != NONE);

endmodule
`default_nettype wire

// File: rtl/fetch_redirect_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_redirect_controller
// Description : Arbitrates decode/execute/trap redirects, holds fetch on
//               cache misses and hazards, drives the PC controls and the
//               wrong-path flush mask.
// Revision    : 1.0  initial release
// ============================================================================
module fetch_redirect_controller
  import fetch_redirect_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int NUM_STAGES   = 7,
  parameter int EX_STAGE     = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  icache_ready,
  input  logic                  decode_hazard,
  input  logic                  dec_jal,
  input  word                   dec_jal_offset,
  input  logic                  ex_redirect,
  input  word                   ex_target,
  input  logic                  trap_req,
  input  word                   trap_vector,
  output logic                  pc_stall,
  output logic                  pc_jump,
  output logic                  pc_jalr,
  output word                   pc_jump_offset,
  output logic [NUM_STAGES-1:0] flush_mask,
  output logic                  busy
);

  typedef enum logic [2:0] {
    BOOT      = 3'd0,
    RUN       = 3'd1,
    MISS_WAIT = 3'd2,
    REDIRECT  = 3'd3,
    FLUSH     = 3'd4
  } state_t;

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] JAL_MASK = NUM_STAGES'(2'b11);
  localparam logic [NUM_STAGES-1:0] EX_MASK  = NUM_STAGES'((64'd1 << EX_STAGE) - 64'd1);

  state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  redirect_kind_t req_kind, merged_kind;
  word            req_value, merged_value;

  redirect_kind_t cap_kind, cap_load_kind, pend_kind, pend_load_kind;
  word            cap_value, cap_load_value, pend_value, pend_load_value;
  logic           cap_valid, pend_valid, cap_clear, pend_clear;
  logic [NUM_STAGES-1:0] kind_mask;

  // Pick the single winning request this cycle; a JAL under a hazard is not a request.
  always_comb begin
    req_kind = highest_kind(trap_req, ex_redirect, dec_jal & ~decode_hazard);
    unique case (req_kind)
      TRAP:    req_value = trap_vector;
      EXEC:    req_value = ex_target;
      JAL:     req_value = dec_jal_offset;
      default: req_value = '0;
    endcase
  end

  // A request arriving on the cycle the miss resolves competes with the pending one.
  always_comb begin
    if (req_kind > pend_kind) begin
      merged_kind  = req_kind;
      merged_value = req_value;
    end else begin
      merged_kind  = pend_kind;
      merged_value = pend_value;
    end
  end

  // Flush extent follows the kind of the redirect being issued.
  always_comb begin
    if (!cap_valid)            kind_mask = '0;
    else if (cap_kind == JAL)  kind_mask = JAL_MASK;
    else                       kind_mask = EX_MASK;
  end

  redirect_slot u_capture (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (cap_clear),
    .load_kind  (cap_load_kind),
    .load_value (cap_load_value),
    .kind       (cap_kind),
    .value      (cap_value),
    .valid      (cap_valid)
  );

  redirect_slot u_pending (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (pend_clear),
    .load_kind  (pend_load_kind),
    .load_value (pend_load_value),
    .kind       (pend_kind),
    .value      (pend_value),
    .valid      (pend_valid)
  );

  // State and flush counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, slot control and PC outputs.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    cap_clear       = 1'b0;
    cap_load_kind   = NONE;
    cap_load_value  = '0;
    pend_clear      = 1'b0;
    pend_load_kind  = NONE;
    pend_load_value = '0;
    pc_stall        = 1'b0;
    pc_jump         = 1'b0;
    pc_jalr         = 1'b0;
    pc_jump_offset  = '0;
    flush_mask      = '0;

    unique case (state)
      BOOT: begin
        pc_stall   = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        pc_stall = decode_hazard | ~icache_ready;
        if (req_kind != NONE) begin
          cap_clear      = 1'b1;
          cap_load_kind  = req_kind;
          cap_load_value = req_value;
          state_next     = REDIRECT;
        end else if (!icache_ready) begin
          state_next = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        pc_stall = 1'b1;
        if (icache_ready) begin
          pend_clear = 1'b1;
          if (pend_valid || (merged_kind != NONE)) begin
            cap_clear      = 1'b1;
            cap_load_kind  = merged_kind;
            cap_load_value = merged_value;
            state_next     = REDIRECT;
          end else begin
            state_next = RUN;
          end
        end else begin
          pend_load_kind  = req_kind;
          pend_load_value = req_value;
        end
      end
      REDIRECT: begin
        pc_jump        = (cap_kind == JAL);
        pc_jalr        = (cap_kind == EXEC) || (cap_kind == TRAP);
        pc_jump_offset = cap_value;
        flush_mask     = kind_mask;
        if (FLUSH_CYCLES > 1) begin
          cnt_next   = CNT_LOAD;
          state_next = FLUSH;
        end else begin
          state_next = RUN;
        end
      end
      FLUSH: begin
        flush_mask = kind_mask;
        pc_stall   = ~icache_ready;
        if (trap_req) begin
          // Traps are never wrong-path; re-issue immediately.
          cap_clear      = 1'b1;
          cap_load_kind  = TRAP;
          cap_load_value = trap_vector;
          cnt_next       = '0;
          state_next     = REDIRECT;
        end else if (cnt <= CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = RUN;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  assign busy = (state != RUN);

endmodule
`default_nettype wire
